// File: rtl/systolic_array_ctrl_pkg.sv
// rtl/systolic_array_ctrl_pkg.sv - shared types, defaults and width helper for the systolic array sequencer
package systolic_array_ctrl_pkg;

  localparam int WIDTH_DATA   = 16;
  localparam int ROWS_DEF     = 4;
  localparam int COLS_DEF     = 4;
  localparam int K_MAX_DEF    = 256;
  localparam int T_MAX_DEF    = 1024;
  localparam int PIPE_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FIN    = 2'd2
  } state_t;

  // Bits needed to index n distinct values, never less than one.
  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_skew_lane_gen.sv
// rtl/systolic_array_ctrl_skew_lane_gen.sv - one skewed lane enable: offset <= t < offset + k_len
module skew_lane_gen #(
  parameter int TW = 9,
  parameter int KW = 9
) (
  input  logic [TW-1:0] t,
  input  logic [TW-1:0] offset,
  input  logic [KW-1:0] k_len,
  output logic          en
);

  // One extra bit so offset + k_len can never wrap.
  localparam int CW = ((TW > KW) ? TW : KW) + 1;

  logic [CW-1:0] t_x;
  logic [CW-1:0] lo_x;
  logic [CW-1:0] hi_x;

  // Window compare of the tile cycle counter against this lane's read window.
  always_comb begin
    t_x  = CW'(t);
    lo_x = CW'(offset);
    hi_x = lo_x + CW'(k_len);
    en   = (t_x >= lo_x) && (t_x < hi_x);
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - tile sequencer driving skewed buffer reads and psum capture strobes
module systolic_array_ctrl
  import systolic_array_ctrl_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int K_MAX    = K_MAX_DEF,
  parameter int T_MAX    = T_MAX_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [bits_for(K_MAX+1)-1:0]  k_len,
  input  logic [bits_for(T_MAX+1)-1:0]  n_tiles,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic                          err,
  output logic [COLS-1:0]               w_rd_en,
  output logic [ROWS-1:0]               fm_rd_en,
  output logic [COLS-1:0]               psum_vld,
  output logic [bits_for(T_MAX)-1:0]    tile_idx
);

  localparam int KW  = bits_for(K_MAX + 1);
  localparam int NW  = bits_for(T_MAX + 1);
  localparam int TIW = bits_for(T_MAX);
  localparam int TW  = bits_for(K_MAX + ROWS + COLS + PIPE_LAT + 1);
  localparam int CW  = ((TW > KW) ? TW : KW) + 1;

  state_t          state;
  logic [TW-1:0]   t;
  logic [KW-1:0]   k_q;
  logic [NW-1:0]   n_q;

  logic [COLS-1:0] w_en_c;
  logic [ROWS-1:0] fm_en_c;
  logic [COLS-1:0] psum_c;
  logic [CW-1:0]   t_end;
  logic            at_end;
  logic            last_tile;
  logic            start_ok;

  // Weight lanes open at t = c, one column per cycle of skew.
  for (genvar c = 0; c < COLS; c++) begin : g_w_lane
    skew_lane_gen #(.TW(TW), .KW(KW)) u_w_lane (
      .t      (t),
      .offset (TW'(c)),
      .k_len  (k_q),
      .en     (w_en_c[c])
    );
  end

  // Fm lanes open one cycle later than the matching weight lane to cover the PE weight shift stage.
  for (genvar r = 0; r < ROWS; r++) begin : g_fm_lane
    skew_lane_gen #(.TW(TW), .KW(KW)) u_fm_lane (
      .t      (t),
      .offset (TW'(r + 1)),
      .k_len  (k_q),
      .en     (fm_en_c[r])
    );
  end

  // Bottom-row psum of column c is complete once the full skew plus pipeline latency has drained.
  for (genvar c = 0; c < COLS; c++) begin : g_psum
    assign psum_c[c] = (CW'(t) == (CW'(k_q) + CW'(ROWS + c + PIPE_LAT - 1)));
  end

  assign t_end     = CW'(k_q) + CW'(ROWS + COLS - 1 + PIPE_LAT);
  assign at_end    = (CW'(t) == t_end);
  assign last_tile = ((NW'(tile_idx) + NW'(1)) >= n_q);
  assign start_ok  = (k_len != '0) && (n_tiles != '0);

  // Job FSM, tile/cycle counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      t        <= '0;
      tile_idx <= '0;
      k_q      <= '0;
      n_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      err      <= 1'b0;
      w_rd_en  <= '0;
      fm_rd_en <= '0;
      psum_vld <= '0;
    end else begin
      done     <= 1'b0;
      aborted  <= 1'b0;
      err      <= 1'b0;
      w_rd_en  <= '0;
      fm_rd_en <= '0;
      psum_vld <= '0;
      if (abort && (state != ST_IDLE)) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        t        <= '0;
        tile_idx <= '0;
        aborted  <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              if (start_ok) begin
                state    <= ST_STREAM;
                busy     <= 1'b1;
                k_q      <= k_len;
                n_q      <= n_tiles;
                t        <= '0;
                tile_idx <= '0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ST_STREAM: begin
            w_rd_en  <= w_en_c;
            fm_rd_en <= fm_en_c;
            psum_vld <= psum_c;
            if (at_end) begin
              t <= '0;
              if (last_tile) begin
                state <= ST_FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                tile_idx <= tile_idx + TIW'(1);
              end
            end else begin
              t <= t + TW'(1);
            end
          end
          ST_FIN: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb/tb_systolic_array_ctrl.sv - directed self-checking bench for systolic_array_ctrl
module tb_systolic_array_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  k_len = '0;
  logic [10:0] n_tiles = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        err;
  logic [3:0]  w_rd_en;
  logic [3:0]  fm_rd_en;
  logic [3:0]  psum_vld;
  logic [9:0]  tile_idx;

  int tests = 0;
  int fails = 0;

  systolic_array_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .k_len    (k_len),
    .n_tiles  (n_tiles),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .err      (err),
    .w_rd_en  (w_rd_en),
    .fm_rd_en (fm_rd_en),
    .psum_vld (psum_vld),
    .tile_idx (tile_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {w_rd_en, fm_rd_en, psum_vld} for tile cycle tt, ROWS=COLS=4, PIPE_LAT=2.
  function automatic logic [11:0] sched(input int tt, input int k);
    logic [3:0] w, f, p;
    for (int i = 0; i < 4; i++) begin
      w[i] = (tt >= i) && (tt < i + k);
      f[i] = (tt >= i + 1) && (tt < i + 1 + k);
      p[i] = (tt == k + 4 + i + 2 - 1);
    end
    return {w, f, p};
  endfunction

  task automatic run_job(input int k, input int n, input bit hold_start);
    int tend;
    int pulses;
    bit last;
    tend   = k + 4 + 4 - 1 + 2;
    pulses = 0;
    k_len   = 9'(k);
    n_tiles = 11'(n);
    start   = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("accept_tile0", {22'd0, tile_idx}, 32'd0);
    for (int tile = 0; tile < n; tile++) begin
      for (int tt = 0; tt <= tend; tt++) begin
        step();
        last = (tile == n - 1) && (tt == tend);
        check("sched", {20'd0, w_rd_en, fm_rd_en, psum_vld}, {20'd0, sched(tt, k)});
        check("flags", {28'd0, busy, done, aborted, err}, {28'd0, !last, last, 1'b0, 1'b0});
        if (tt < tend) check("tile_idx", {22'd0, tile_idx}, 32'(tile));
        pulses += $countones(psum_vld);
        if (k == 8 && tile == 0) begin
          if (tt == 2)  check("w3_t2", {31'd0, w_rd_en[3]}, 32'd0);
          if (tt == 3)  check("w3_t3", {31'd0, w_rd_en[3]}, 32'd1);
          if (tt == 10) check("w3_t10", {31'd0, w_rd_en[3]}, 32'd1);
          if (tt == 11) check("w3_t11", {31'd0, w_rd_en[3]}, 32'd0);
          if (tt == 3)  check("fm3_t3", {31'd0, fm_rd_en[3]}, 32'd0);
          if (tt == 4)  check("fm3_t4", {31'd0, fm_rd_en[3]}, 32'd1);
          if (tt == 11) check("fm3_t11", {31'd0, fm_rd_en[3]}, 32'd1);
          if (tt == 12) check("fm3_t12", {31'd0, fm_rd_en[3]}, 32'd0);
          if (tt == 13) check("psum_t13", {28'd0, psum_vld}, 32'h1);
          if (tt == 16) check("psum_t16", {28'd0, psum_vld}, 32'h8);
        end
      end
    end
    step();
    start = 1'b0;
    check("post_fin", {28'd0, busy, done, aborted, err}, 32'd0);
    check("psum_count", 32'(pulses), 32'(n * 4));
  endtask

  initial begin
    #2;
    check("reset_outputs", {16'd0, busy, done, aborted, err, w_rd_en, fm_rd_en, psum_vld}, 32'd0);
    check("reset_tile_idx", {22'd0, tile_idx}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // single tile, k=8
    run_job(8, 1, 1'b0);

    // three back-to-back tiles, k=1, start held high throughout the job
    run_job(1, 3, 1'b1);

    // illegal starts
    k_len = 9'd0; n_tiles = 11'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("err_k0", {28'd0, busy, done, aborted, err}, 32'd1);
    step();
    check("err_k0_clear", {28'd0, busy, done, aborted, err}, 32'd0);
    check("err_k0_no_en", {20'd0, w_rd_en, fm_rd_en, psum_vld}, 32'd0);
    k_len = 9'd4; n_tiles = 11'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("err_n0", {28'd0, busy, done, aborted, err}, 32'd1);
    step();
    check("err_n0_idle", {16'd0, busy, done, aborted, err, w_rd_en, fm_rd_en, psum_vld}, 32'd0);

    // abort together with start in IDLE: start dropped, no pulses
    k_len = 9'd4; n_tiles = 11'd1; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", {28'd0, busy, done, aborted, err}, 32'd0);
    step();
    check("abort_start_idle2", {28'd0, busy, done, aborted, err}, 32'd0);

    // abort at t=6 of the second tile of two, k=8
    k_len = 9'd8; n_tiles = 11'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 24; j++) step();
    check("pre_abort_tile", {22'd0, tile_idx}, 32'd1);
    check("pre_abort_en", {24'd0, w_rd_en, fm_rd_en}, 32'hff);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_outputs", {16'd0, busy, done, aborted, err, w_rd_en, fm_rd_en, psum_vld}, 32'h2000);
    check("abort_tile_idx", {22'd0, tile_idx}, 32'd0);
    for (int j = 0; j < 20; j++) begin
      step();
      check("post_abort_quiet", {16'd0, busy, done, aborted, err, w_rd_en, fm_rd_en, psum_vld}, 32'd0);
    end
    run_job(2, 2, 1'b0);

    // asynchronous reset mid-stream
    k_len = 9'd8; n_tiles = 11'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 5; j++) step();
    check("pre_reset_en", {24'd0, w_rd_en, fm_rd_en}, 32'hff);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {16'd0, busy, done, aborted, err, w_rd_en, fm_rd_en, psum_vld}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("after_reset_idle", {16'd0, busy, done, aborted, err, w_rd_en, fm_rd_en, psum_vld}, 32'd0);
    run_job(8, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
